puzzle3_kdigit: RTL and testbench

- Streaming "maximum K-digit subsequence" accumulator for the day-3 battery-bank puzzle, generalised over the pick count K.
- K=2 is part 1 and K=12 is part 2.
- Digits of a bank stream in one per cycle. A dynamic-programming register array keeps the best j-digit value for every j=1..K without buffering the bank.
- At each bank close, the best K-digit value is emitted and added to a running sum.

---
 rtl/puzzle3_kdigit_if.sv | 10 +
 rtl/puzzle3_kdigit.sv | 134 +++++++++++++
 tb/tb_puzzle3_kdigit.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/puzzle3_kdigit_if.sv
// Digit stream into the K-digit accumulator: one optional digit per cycle
// plus a bank-close strobe that may ride on the same cycle.
interface puzzle3_kdigit_if;
    logic [3:0] data_in;
    logic       wr_en;
    logic       bank_end;

    modport master (output data_in, output wr_en, output bank_end);
    modport slave  (input  data_in, input  wr_en, input  bank_end);
endinterface

// File: rtl/puzzle3_kdigit.sv
// Streaming maximum-K-digit-subsequence accumulator.
// best_q[j] holds the largest j-digit value that can be picked, in order,
// from the digits seen so far in the current bank. All j update in parallel
// from pre-edge values, so no bank buffering is needed. On bank close the
// K-digit result is registered (stage 1) and added to the running sum one
// cycle later (stage 2).
module puzzle3_kdigit #(
    parameter int DIGITS = 12,
    parameter int VAL_W  = 40,
    parameter int SUM_W  = 64,
    parameter int CNT_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    puzzle3_kdigit_if.slave      in_if,
    output logic                 bank_valid,
    output logic [VAL_W-1:0]     bank_max,
    output logic                 bank_short,
    output logic [SUM_W-1:0]     sum,
    output logic [CNT_W-1:0]     bank_count,
    output logic                 digit_err
);

    // Larger of two unsigned values of equal digit count.
    function automatic logic [VAL_W-1:0] max_u(input logic [VAL_W-1:0] a,
                                               input logic [VAL_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

    // Append a decimal digit: v*10 + d, built from shifts to avoid a multiplier.
    function automatic logic [VAL_W-1:0] mul10_add(input logic [VAL_W-1:0] v,
                                                   input logic [3:0]       d);
        return (v << 3) + (v << 1) + VAL_W'(d);
    endfunction

    // Increment that sticks at lim.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic [CNT_W-1:0] lim);
        return (v >= lim) ? v : v + CNT_W'(1);
    endfunction

    logic [VAL_W-1:0] best_q  [1:DIGITS];
    logic [VAL_W-1:0] best_d  [1:DIGITS];
    logic [VAL_W-1:0] best_nx [1:DIGITS];
    logic [CNT_W-1:0] n_q, n_d, n_nx;
    logic             accept;

    logic             bank_valid_q, bank_valid_d;
    logic [VAL_W-1:0] bank_max_q,   bank_max_d;
    logic             bank_short_q, bank_short_d;
    logic [SUM_W-1:0] sum_q,        sum_d;
    logic [CNT_W-1:0] bank_count_q, bank_count_d;
    logic             digit_err_q,  digit_err_d;

    // DP step: fold the incoming digit into every best[j] (j needs j-1 prior digits).
    always_comb begin
        accept = in_if.wr_en && (in_if.data_in <= 4'd9);
        for (int j = 1; j <= DIGITS; j++) begin
            best_nx[j] = best_q[j];
        end
        n_nx = n_q;
        if (accept) begin
            best_nx[1] = max_u(best_q[1], VAL_W'(in_if.data_in));
            for (int j = 2; j <= DIGITS; j++) begin
                if (n_q >= CNT_W'(j - 1)) begin
                    best_nx[j] = max_u(best_q[j], mul10_add(best_q[j-1], in_if.data_in));
                end
            end
            n_nx = sat_inc(n_q, CNT_W'(DIGITS));
        end
    end

    // Bank close capture, DP clear, sticky error and the delayed accumulate.
    always_comb begin
        best_d       = best_nx;
        n_d          = n_nx;
        bank_valid_d = in_if.bank_end;
        bank_max_d   = bank_max_q;
        bank_short_d = bank_short_q;
        sum_d        = sum_q;
        bank_count_d = bank_count_q;
        digit_err_d  = digit_err_q | (in_if.wr_en && (in_if.data_in > 4'd9));

        if (in_if.bank_end) begin
            // A short bank never fills best[DIGITS]; report it explicitly as 0.
            bank_short_d = (n_nx < CNT_W'(DIGITS));
            bank_max_d   = bank_short_d ? '0 : best_nx[DIGITS];
            for (int j = 1; j <= DIGITS; j++) begin
                best_d[j] = '0;
            end
            n_d = '0;
        end

        if (bank_valid_q) begin
            sum_d        = sum_q + SUM_W'(bank_max_q);
            bank_count_d = sat_inc(bank_count_q, {CNT_W{1'b1}});
        end
    end

    // State registers; reset discards any partial bank immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 1; j <= DIGITS; j++) begin
                best_q[j] <= '0;
            end
            n_q          <= '0;
            bank_valid_q <= 1'b0;
            bank_max_q   <= '0;
            bank_short_q <= 1'b0;
            sum_q        <= '0;
            bank_count_q <= '0;
            digit_err_q  <= 1'b0;
        end else begin
            for (int j = 1; j <= DIGITS; j++) begin
                best_q[j] <= best_d[j];
            end
            n_q          <= n_d;
            bank_valid_q <= bank_valid_d;
            bank_max_q   <= bank_max_d;
            bank_short_q <= bank_short_d;
            sum_q        <= sum_d;
            bank_count_q <= bank_count_d;
            digit_err_q  <= digit_err_d;
        end
    end

    assign bank_valid = bank_valid_q;
    assign bank_max   = bank_max_q;
    assign bank_short = bank_short_q;
    assign sum        = sum_q;
    assign bank_count = bank_count_q;
    assign digit_err  = digit_err_q;

endmodule

// File: tb/tb_puzzle3_kdigit.sv
// Directed bench: a K=12 and a K=2 instance share clock and reset; each step
// drives one cycle of stimulus and checks against hand-computed values.
module tb_puzzle3_kdigit;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    puzzle3_kdigit_if if12 ();
    puzzle3_kdigit_if if2 ();

    logic        v12, s12, e12;
    logic [39:0] m12;
    logic [63:0] sum12;
    logic [7:0]  c12;
    logic        v2, s2, e2;
    logic [39:0] m2;
    logic [63:0] sum2;
    logic [7:0]  c2;

    puzzle3_kdigit #(.DIGITS(12), .VAL_W(40), .SUM_W(64), .CNT_W(8)) u12 (
        .clk(clk), .rst_n(rst_n), .in_if(if12),
        .bank_valid(v12), .bank_max(m12), .bank_short(s12),
        .sum(sum12), .bank_count(c12), .digit_err(e12));

    puzzle3_kdigit #(.DIGITS(2), .VAL_W(40), .SUM_W(64), .CNT_W(8)) u2 (
        .clk(clk), .rst_n(rst_n), .in_if(if2),
        .bank_valid(v2), .bank_max(m2), .bank_short(s2),
        .sum(sum2), .bank_count(c2), .digit_err(e2));

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic idle();
        if12.data_in = 4'd0; if12.wr_en = 1'b0; if12.bank_end = 1'b0;
        if2.data_in  = 4'd0; if2.wr_en  = 1'b0; if2.bank_end  = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle of stimulus to the selected instance(s), then back to idle.
    task automatic drive(input bit to12, input bit to2, input logic [3:0] d,
                         input bit we, input bit be);
        idle();
        if (to12) begin if12.data_in = d; if12.wr_en = we; if12.bank_end = be; end
        if (to2)  begin if2.data_in  = d; if2.wr_en  = we; if2.bank_end  = be; end
        tick();
        idle();
    endtask

    task automatic feed(input bit to12, input bit to2, input string s, input bit close);
        logic [7:0] c;
        for (int i = 0; i < s.len(); i++) begin
            c = s[i] - 8'h30;
            drive(to12, to2, c[3:0], 1'b1, close && (i == s.len() - 1));
        end
    endtask

    string       banks [4];
    logic [63:0] exp12 [4];
    logic [63:0] exp2  [4];

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        banks[0] = "987654321111111"; exp12[0] = 64'd987654321111; exp2[0] = 64'd98;
        banks[1] = "811111111111119"; exp12[1] = 64'd811111111119; exp2[1] = 64'd89;
        banks[2] = "234234234234278"; exp12[2] = 64'd434234234278; exp2[2] = 64'd78;
        banks[3] = "818181911112111"; exp12[3] = 64'd888911112111; exp2[3] = 64'd92;

        idle();
        rst_n = 1'b0;
        tick();
        tick();
        chk("rst_valid", 64'(v12), 64'd0);
        chk("rst_max",   64'(m12), 64'd0);
        chk("rst_sum",   sum12,    64'd0);
        chk("rst_count", 64'(c12), 64'd0);
        chk("rst_err",   64'(e12), 64'd0);
        chk("rst_short", 64'(s12), 64'd0);
        rst_n = 1'b1;
        tick();

        // Four puzzle banks into both instances, bank_end on the last digit.
        for (int b = 0; b < 4; b++) begin
            feed(1'b1, 1'b1, banks[b], 1'b1);
            chk($sformatf("k12_valid%0d", b), 64'(v12), 64'd1);
            chk($sformatf("k12_max%0d", b),   64'(m12), exp12[b]);
            chk($sformatf("k12_short%0d", b), 64'(s12), 64'd0);
            chk($sformatf("k2_valid%0d", b),  64'(v2),  64'd1);
            chk($sformatf("k2_max%0d", b),    64'(m2),  exp2[b]);
        end
        tick();
        chk("k12_valid_drop", 64'(v12), 64'd0);
        chk("k12_sum",   sum12,    64'd3121910778619);
        chk("k12_count", 64'(c12), 64'd4);
        chk("k2_sum",    sum2,     64'd357);
        chk("k2_count",  64'(c2),  64'd4);

        // Short bank on K=12, closed by a bank_end-only cycle.
        feed(1'b1, 1'b0, "12345", 1'b0);
        drive(1'b1, 1'b0, 4'd0, 1'b0, 1'b1);
        chk("short_valid", 64'(v12), 64'd1);
        chk("short_max",   64'(m12), 64'd0);
        chk("short_flag",  64'(s12), 64'd1);
        tick();
        chk("short_sum",   sum12,    64'd3121910778619);
        chk("short_count", 64'(c12), 64'd5);

        // K=2: 9,1, newline flush, then an empty bank right behind it.
        drive(1'b0, 1'b1, 4'd9, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 4'd1, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 4'd0, 1'b0, 1'b1);
        chk("flush_valid", 64'(v2), 64'd1);
        chk("flush_max",   64'(m2), 64'd91);
        chk("flush_short", 64'(s2), 64'd0);
        drive(1'b0, 1'b1, 4'd0, 1'b0, 1'b1);
        chk("empty_valid", 64'(v2), 64'd1);
        chk("empty_max",   64'(m2), 64'd0);
        chk("empty_short", 64'(s2), 64'd1);
        tick();
        chk("empty_valid_drop", 64'(v2), 64'd0);
        chk("flush_sum",   sum2,    64'd448);
        chk("flush_count", 64'(c2), 64'd6);

        // K=2: invalid digit 0xC is ignored and flagged stickily.
        drive(1'b0, 1'b1, 4'd5, 1'b1, 1'b0);
        chk("err_before", 64'(e2), 64'd0);
        drive(1'b0, 1'b1, 4'hC, 1'b1, 1'b0);
        chk("err_set", 64'(e2), 64'd1);
        drive(1'b0, 1'b1, 4'd7, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 4'd0, 1'b0, 1'b1);
        chk("err_max",    64'(m2),  64'd57);
        chk("err_sticky", 64'(e2),  64'd1);
        chk("err_other",  64'(e12), 64'd0);
        tick();
        chk("err_sum", sum2, 64'd505);

        // Asynchronous reset in the middle of a K=12 bank.
        feed(1'b1, 1'b0, "123456", 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_sum",   sum12,    64'd0);
        chk("mid_rst_count", 64'(c12), 64'd0);
        chk("mid_rst_max",   64'(m12), 64'd0);
        chk("mid_rst_err2",  64'(e2),  64'd0);
        chk("mid_rst_sum2",  sum2,     64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        feed(1'b1, 1'b0, "999999999999", 1'b1);
        chk("post_rst_max",   64'(m12), 64'd999999999999);
        chk("post_rst_short", 64'(s12), 64'd0);
        tick();
        chk("post_rst_sum",   sum12,    64'd999999999999);
        chk("post_rst_count", 64'(c12), 64'd1);

        // K=2 bank counter saturates at 255.
        repeat (260) drive(1'b0, 1'b1, 4'd0, 1'b0, 1'b1);
        tick();
        tick();
        chk("sat_count", 64'(c2), 64'd255);
        chk("sat_sum",   sum2,    64'd0);
        chk("sat_short", 64'(s2), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
